dm_wb_cache_ctrl: RTL
=====================

Name: dm_wb_cache_ctrl

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache controller; successor to the fixed 16-line 10-bit cache controller.
- Sits between the CPU load/store port and the DataMemory backing store.
- Adds valid bits, real dirty-victim writeback, and a req/ack handshake on both sides.
- One word per line; word-addressed.

Parameters:
- ADDR_W, 10, CPU word-address width.
- DATA_W, 10, data word width.
- INDEX_W, 4, index bits; line count = 2**INDEX_W; tag width TAG_W = ADDR_W-INDEX_W.
- CNT_W, 16, statistics counter width (used only with CACHE_STATS_EN).

Ports:
- clk  in  1  rising-edge clock (single clock domain).
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  word address; index=cpu_addr[INDEX_W-1:0], tag=upper TAG_W bits.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever state != IDLE.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1=writeback, 0=line fill.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  writeback data.
- mem_rdata  in  DATA_W  fill data, valid with mem_ack.
- mem_ack  in  1  memory completion; ignored while mem_req=0.

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. All outputs registered (Moore).
- Reset (rst_n=0 at an edge): state=IDLE; all valid and dirty bits cleared; cpu_ack, cpu_busy, mem_req, mem_we = 0; cpu_rdata, mem_addr, mem_wdata = 0. Data and tag arrays are not reset.
- Reset mid-miss abandons the transaction. mem_req is low from the first reset edge. No partial line is written.
- IDLE:
  - If cpu_req=1 at edge N, latch addr/we/wdata and go to COMPARE. cpu_busy=1 from edge N.
  - cpu_req while busy is ignored; the CPU must hold it until it sees the ack.
- COMPARE (edge N+1): hit = valid[idx] && tag_arr[idx]==tag.
  - Load hit: cpu_rdata <= data[idx].
  - Store hit: data[idx] <= wdata, dirty[idx] <= 1.
  - On either hit: cpu_ack=1 for exactly one cycle, then go to IDLE.
  - Hit latency is 2 edges from request to ack.
  - Miss with valid && dirty victim: go to WRITEBACK with mem_addr={tag_arr[idx],idx}, mem_wdata=data[idx], mem_we=1, mem_req=1.
  - Miss otherwise: go to ALLOCATE with mem_addr=latched addr, mem_we=0, mem_req=1.
- WRITEBACK:
  - Hold mem_* stable until mem_ack.
  - On the mem_ack edge: clear dirty[idx] and go to ALLOCATE, issuing the fill request on the same edge.
- ALLOCATE:
  - Hold until mem_ack.
  - On the mem_ack edge: data[idx] <= mem_rdata, tag_arr[idx] <= tag, valid[idx] <= 1, dirty[idx] <= 0, mem_req <= 0, return to COMPARE.
  - The re-check in COMPARE is guaranteed to hit, completing the load/store.
- mem_ack may arrive in the first cycle mem_req is high; zero-wait memory is legal.
- Stores never write through; memory is updated only by victim writeback.
- Index wrap: address bits above INDEX_W go only to the tag. Aliased addresses evict each other.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined, adds three outputs, each CNT_W wide, saturating at all-ones, cleared by reset:
  - hit_cnt: +1 per first-pass COMPARE hit.
  - miss_cnt: +1 per COMPARE miss; the re-check hit after a fill is not counted.
  - wb_cnt: +1 per WRITEBACK completion.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset, then load addr 0x005 with mem returning 0x155 after 3 cycles -> one fill at mem_addr 0x005, mem_we=0; cpu_ack with cpu_rdata=0x155; miss_cnt=1.
- Repeat load 0x005 -> cpu_ack 2 edges after req, rdata=0x155, no mem_req; hit_cnt=1.
- Store 0x2AA to 0x005, then load 0x025 (same index 5, new tag) -> writeback mem_addr=0x005, mem_wdata=0x2AA, then fill of 0x025; wb_cnt=1.
- Load 0x045 while index 5 is clean -> fill only, no WRITEBACK.
- Zero-wait memory (mem_ack tied to mem_req) on a dirty miss -> WRITEBACK and ALLOCATE each last 1 cycle; ack at edge N+4.
- rst_n low during ALLOCATE -> mem_req=0 at the next edge; after release, load of the same addr misses (valid cleared).

Source files
------------

// File: rtl/dm_wb_cache_ctrl.sv
// dm_wb_cache_ctrl
//   Direct-mapped, write-back, write-allocate data cache controller placed
//   between a CPU load/store port and a word-addressed backing memory.
//   One data word per line. Each line has a valid bit, a dirty bit, a tag,
//   and a data word. A miss on a dirty victim writes the victim back first,
//   then fills the line. COMPARE is then re-run, and that re-check always hits.
//
// Optional feature
//   CACHE_STATS_EN : when defined, adds saturating hit/miss/writeback counters
//                    (hit_cnt, miss_cnt, wb_cnt), each CNT_W bits wide.
//
// Ports
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   cpu_req      : request valid, sampled only while idle
//   cpu_we       : 1 = store, 0 = load
//   cpu_addr     : word address (low INDEX_W bits = index, rest = tag)
//   cpu_wdata    : store data
//   cpu_rdata    : load data, valid while cpu_ack is high
//   cpu_ack      : one-cycle completion pulse
//   cpu_busy     : high whenever a request is in progress
//   mem_req      : memory request, held until mem_ack
//   mem_we       : 1 = victim writeback, 0 = line fill
//   mem_addr     : memory word address
//   mem_wdata    : writeback data
//   mem_rdata    : fill data, valid with mem_ack
//   mem_ack      : memory completion (ignored while mem_req is low)
//   hit_cnt, miss_cnt, wb_cnt : statistics (CACHE_STATS_EN only)

module dm_wb_cache_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 10,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  if (INDEX_W < 1 || INDEX_W >= ADDR_W || CNT_W < 1) begin : g_param_check
    $error("dm_wb_cache_ctrl: need 1 <= INDEX_W < ADDR_W and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  // Control state (reset)
  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic               refill_q, refill_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               cpu_busy_q, cpu_busy_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  // Datapath storage (not reset)
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               req_we_q, req_we_d;
  logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0]  data_arr_q [LINES];
  logic [TAG_W-1:0]   tag_arr_q  [LINES];

  logic               arr_we;
  logic [DATA_W-1:0]  arr_wdata;
  logic               tag_we;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;

  assign req_idx = req_addr_q[INDEX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];
  assign hit     = valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    refill_d    = refill_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    arr_we      = 1'b0;
    arr_wdata   = req_wdata_q;
    tag_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          req_addr_d  = cpu_addr;
          req_we_d    = cpu_we;
          req_wdata_d = cpu_wdata;
          refill_d    = 1'b0;
          state_d     = S_COMPARE;
        end
      end

      S_COMPARE: begin
        if (hit) begin
          if (req_we_q) begin
            arr_we           = 1'b1;
            arr_wdata        = req_wdata_q;
            dirty_d[req_idx] = 1'b1;
          end else begin
            cpu_rdata_d = data_arr_q[req_idx];
          end
          cpu_ack_d = 1'b1;
          state_d   = S_IDLE;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          // Victim address is rebuilt from its stored tag and this index.
          mem_addr_d  = {tag_arr_q[req_idx], req_idx};
          mem_wdata_d = data_arr_q[req_idx];
          mem_we_d    = 1'b1;
          mem_req_d   = 1'b1;
          state_d     = S_WRITEBACK;
        end else begin
          mem_addr_d = req_addr_q;
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
          state_d    = S_ALLOCATE;
        end
      end

      S_WRITEBACK: begin
        if (mem_ack) begin
          // Fill request goes out on the same edge the writeback completes.
          dirty_d[req_idx] = 1'b0;
          mem_addr_d       = req_addr_q;
          mem_we_d         = 1'b0;
          mem_req_d        = 1'b1;
          state_d          = S_ALLOCATE;
        end
      end

      S_ALLOCATE: begin
        if (mem_ack) begin
          arr_we           = 1'b1;
          arr_wdata        = mem_rdata;
          tag_we           = 1'b1;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          mem_req_d        = 1'b0;
          refill_d         = 1'b1;
          state_d          = S_COMPARE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    cpu_busy_d = (state_d != S_IDLE);
  end

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The post-fill re-check is not a first-pass hit, so it is not counted.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == S_COMPARE && hit && !refill_q) hit_cnt_d  = sat_inc(hit_cnt_q);
    if (state_q == S_COMPARE && !hit)             miss_cnt_d = sat_inc(miss_cnt_q);
    if (state_q == S_WRITEBACK && mem_ack)        wb_cnt_d   = sat_inc(wb_cnt_q);
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      refill_q    <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_busy_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      refill_q    <= refill_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_busy_q  <= cpu_busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
`endif
    end
  end

  // Array writes are suppressed during reset so an abandoned fill never
  // lands a partial line.
  always_ff @(posedge clk) begin
    req_addr_q  <= req_addr_d;
    req_we_q    <= req_we_d;
    req_wdata_q <= req_wdata_d;
    if (rst_n && arr_we) data_arr_q[req_idx] <= arr_wdata;
    if (rst_n && tag_we) tag_arr_q[req_idx]  <= req_tag;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_busy  = cpu_busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
